mul_arbiter: RTL and testbench



---
 rtl/mul_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/mul_arbiter.sv | 139 +++++++++++++
 tb/tb_mul_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and sizing for the multiplier-sharing arbiter.
package mul_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int ID_W        = 2;
  localparam int TIMEOUT_DEF = 32;
  localparam int OP_W        = 8;
  localparam int PROD_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i.
module rr_arbiter
  import mul_pkg::*;
(
  input  logic [NREQ_DEF-1:0] req_i,
  input  logic [ID_W-1:0]     ptr_i,
  output logic [ID_W-1:0]     winner_o,
  output logic                found_o
);

  logic [ID_W-1:0] idx;

  // Scan requesters starting at the pointer; the 2-bit index wraps naturally.
  always_comb begin
    found_o  = 1'b0;
    winner_o = '0;
    idx      = '0;
    for (int k = 0; k < NREQ_DEF; k++) begin
      idx = ptr_i + ID_W'(k);
      if (!found_o && req_i[idx]) begin
        found_o  = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one external multiplier among four requesters, round-robin,
// with a stale-valid guard and a WAIT timeout.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no operation; grant the next requester when any req is high
// ST_ISSUE | mul_start pulse with the latched operands, clear the counter
// ST_WAIT  | wait for mul_valid (ignored in the first cycle) or timeout
// ST_RESP  | rsp_valid pulse with registered id/product/error
module mul_arbiter
  import mul_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [OP_W*NREQ-1:0] req_x,
  input  logic [OP_W*NREQ-1:0] req_y,
  output logic [NREQ-1:0]      req_ack,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [PROD_W-1:0]    rsp_z,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 mul_start,
  output logic [OP_W-1:0]      mul_x,
  output logic [OP_W-1:0]      mul_y,
  input  logic [PROD_W-1:0]    mul_z,
  input  logic                 mul_valid
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [OP_W-1:0]     mul_x_q, mul_x_d;
  logic [OP_W-1:0]     mul_y_q, mul_y_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [PROD_W-1:0]   rsp_z_q, rsp_z_d;
  logic                rsp_err_q, rsp_err_d;

  logic [ID_W-1:0]     winner;
  logic                found;

  rr_arbiter u_rr (
    .req_i    (req),
    .ptr_i    (rr_ptr_q),
    .winner_o (winner),
    .found_o  (found)
  );

  // Next-state, grant and response capture; every register holds by default.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    mul_x_d   = mul_x_q;
    mul_y_d   = mul_y_q;
    rsp_id_d  = rsp_id_q;
    rsp_z_d   = rsp_z_q;
    rsp_err_d = rsp_err_q;
    req_ack   = '0;
    unique case (state_q)
      ST_IDLE: begin
        // Gated by reset so no ack is shown while the block is being cleared.
        if (found && !reset) begin
          req_ack[winner] = 1'b1;
          id_d            = winner;
          mul_x_d         = req_x[int'(winner)*OP_W +: OP_W];
          mul_y_d         = req_y[int'(winner)*OP_W +: OP_W];
          rr_ptr_d        = winner + 2'd1;
          state_d         = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A done flag left high by the previous operation is not trusted
        // in the first WAIT cycle.
        if ((cnt_q != '0) && mul_valid) begin
          rsp_z_d   = mul_z;
          rsp_err_d = 1'b0;
          rsp_id_d  = id_q;
          state_d   = ST_RESP;
        end else if (cnt_d == CNT_W'(TIMEOUT)) begin
          rsp_z_d   = '0;
          rsp_err_d = 1'b1;
          rsp_id_d  = id_q;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      id_q      <= '0;
      mul_x_q   <= '0;
      mul_y_q   <= '0;
      rsp_id_q  <= '0;
      rsp_z_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      mul_x_q   <= mul_x_d;
      mul_y_q   <= mul_y_d;
      rsp_id_q  <= rsp_id_d;
      rsp_z_q   <= rsp_z_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign mul_start = (state_q == ST_ISSUE);
  assign rsp_valid = (state_q == ST_RESP);
  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a behavioural multiplier and
// requesters that drop req the cycle after their ack.
module tb_mul_arbiter;

  localparam int M_NORMAL = 0;
  localparam int M_NEVER  = 1;
  localparam int M_STALE  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_x, req_y;
  logic [3:0]  req_ack;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_z;
  logic        rsp_err;
  logic        busy;
  logic        mul_start;
  logic [7:0]  mul_x, mul_y;
  logic [15:0] mul_z;
  logic        mul_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int                 mode, lat, dly;
  bit                 pend;
  logic signed [15:0] prod;
  logic [3:0]         ack_prev;

  int          g_id[$], g_cyc[$], s_cyc[$], r_cyc[$];
  logic [1:0]  r_id[$];
  logic [15:0] r_z[$];
  logic        r_err[$];

  always #5 clk = ~clk;

  mul_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_ack   (req_ack),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_z     (rsp_z),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .mul_start (mul_start),
    .mul_x     (mul_x),
    .mul_y     (mul_y),
    .mul_z     (mul_z),
    .mul_valid (mul_valid)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: sample outputs, update requesters and multiplier model, advance.
  task automatic tick();
    logic [3:0] ack_now;
    #1;
    ack_now = req_ack;
    if (ack_now != 4'b0) begin
      check_eq("ack_onehot", 32'($countones(ack_now)), 32'd1);
      check_eq("ack_idle", 32'(busy), 32'd0);
      for (int i = 0; i < 4; i++) if (ack_now[i]) g_id.push_back(i);
      g_cyc.push_back(cyc);
    end
    if (mul_start) s_cyc.push_back(cyc);
    if (rsp_valid) begin
      r_id.push_back(rsp_id);
      r_z.push_back(rsp_z);
      r_err.push_back(rsp_err);
      r_cyc.push_back(cyc);
    end
    req      = req & ~ack_prev;
    ack_prev = ack_now;
    if (mul_start) begin
      prod = $signed({{8{mul_x[7]}}, mul_x}) * $signed({{8{mul_y[7]}}, mul_y});
      dly  = lat;
      pend = 1'b1;
      if (mode != M_STALE) mul_valid = 1'b0;
    end else if (pend) begin
      if (dly > 1) dly--;
      else begin
        pend = 1'b0;
        if (mode != M_NEVER) begin
          mul_z     = prod;
          mul_valid = 1'b1;
        end
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_logs();
    g_id.delete(); g_cyc.delete(); s_cyc.delete(); r_cyc.delete();
    r_id.delete(); r_z.delete(); r_err.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset    = 1'b0;
    pend     = 1'b0;
    ack_prev = '0;
    clear_logs();
  endtask

  task automatic set_op(input int i, input logic [7:0] x, input logic [7:0] y);
    req_x[8*i +: 8] = x;
    req_y[8*i +: 8] = y;
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int k = 0;
    while (r_z.size() < n && k < budget) begin
      tick();
      k++;
    end
    check_eq("rsp_count", 32'(r_z.size()), 32'(n));
  endtask

  task automatic check_grant(input int k, input int id);
    check_eq("grant_seen", 32'(g_id.size() > k), 32'd1);
    if (g_id.size() > k) check_eq("grant_id", 32'(g_id[k]), 32'(id));
  endtask

  task automatic check_rsp(input int k, input logic [1:0] id, input logic [15:0] z, input logic err);
    if (r_z.size() > k) begin
      check_eq("rsp_id", {30'b0, r_id[k]}, {30'b0, id});
      check_eq("rsp_z", {16'b0, r_z[k]}, {16'b0, z});
      check_eq("rsp_err", {31'b0, r_err[k]}, {31'b0, err});
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_req_ack"},   32'(req_ack),   32'd0);
    check_eq({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({pfx, "_rsp_id"},    32'(rsp_id),    32'd0);
    check_eq({pfx, "_rsp_z"},     32'(rsp_z),     32'd0);
    check_eq({pfx, "_rsp_err"},   32'(rsp_err),   32'd0);
    check_eq({pfx, "_busy"},      32'(busy),      32'd0);
    check_eq({pfx, "_mul_start"}, 32'(mul_start), 32'd0);
    check_eq({pfx, "_mul_x"},     32'(mul_x),     32'd0);
    check_eq({pfx, "_mul_y"},     32'(mul_y),     32'd0);
  endtask

  initial begin
    reset = 1'b1; req = '0; req_x = '0; req_y = '0;
    mul_z = '0; mul_valid = 1'b0;
    mode = M_NORMAL; lat = 3; dly = 0; pend = 1'b0; prod = '0; ack_prev = '0;
    @(negedge clk);

    // Reset state
    do_reset();
    check_all_zero("rst");

    // Single request: 5*3 from requester 0, latency 3
    set_op(0, 8'd5, 8'd3);
    req = 4'b0001;
    wait_rsp(1, 40);
    check_grant(0, 0);
    check_rsp(0, 2'd0, 16'd15, 1'b0);
    if (g_cyc.size() > 0 && s_cyc.size() > 0 && r_cyc.size() > 0) begin
      check_eq("start_after_ack", 32'(s_cyc[0] - g_cyc[0]), 32'd1);
      check_eq("rsp_latency", 32'(r_cyc[0] - g_cyc[0]), 32'd5);
    end

    // All four from reset: order 0,1,2,3
    req = 4'hF;
    set_op(0, 8'hFA, 8'h02);   // -6 * 2
    set_op(1, 8'h0F, 8'hFC);   // 15 * -4
    set_op(2, 8'hF9, 8'hF9);   // -7 * -7
    set_op(3, 8'h64, 8'hFF);   // 100 * -1
    do_reset();
    wait_rsp(4, 120);
    check_grant(0, 0); check_grant(1, 1); check_grant(2, 2); check_grant(3, 3);
    check_rsp(0, 2'd0, 16'hFFF4, 1'b0);   // -12
    check_rsp(1, 2'd1, 16'hFFC4, 1'b0);   // -60
    check_rsp(2, 2'd2, 16'h0031, 1'b0);   //  49
    check_rsp(3, 2'd3, 16'hFF9C, 1'b0);   // -100

    // Operand extremes on requester 2, then pointer wrap to 3
    do_reset();
    set_op(2, 8'h80, 8'h01);
    req = 4'b0100;
    wait_rsp(1, 40);
    check_rsp(0, 2'd2, 16'hFF80, 1'b0);   // -128
    set_op(2, 8'h7F, 8'h01);
    req = 4'b0100;
    wait_rsp(2, 40);
    check_rsp(1, 2'd2, 16'h007F, 1'b0);   // 127
    set_op(1, 8'h02, 8'h03);
    set_op(3, 8'hFE, 8'h05);
    req = 4'b1010;
    wait_rsp(4, 80);
    check_grant(2, 3);
    check_grant(3, 1);
    check_rsp(2, 2'd3, 16'hFFF6, 1'b0);   // -10
    check_rsp(3, 2'd1, 16'h0006, 1'b0);   //  6

    // Timeout: multiplier never answers
    do_reset();
    mode = M_NEVER;
    set_op(1, 8'h03, 8'h03);
    req = 4'b0010;
    wait_rsp(1, 60);
    check_rsp(0, 2'd1, 16'h0000, 1'b1);
    if (s_cyc.size() > 0 && r_cyc.size() > 0)
      check_eq("timeout_cycles", 32'(r_cyc[0] - (s_cyc[0] + 1)), 32'd32);
    check_eq("timeout_idle_busy", 32'(busy), 32'd0);
    check_eq("timeout_idle_rsp", 32'(rsp_valid), 32'd0);

    // Stale valid: flag high throughout, old value visible in first WAIT cycle
    do_reset();
    mode = M_STALE;
    lat = 2;
    mul_valid = 1'b1;
    mul_z = 16'h7777;
    set_op(2, 8'hFD, 8'h09);   // -3 * 9
    req = 4'b0100;
    wait_rsp(1, 30);
    check_rsp(0, 2'd2, 16'hFFE5, 1'b0);   // -27
    if (s_cyc.size() > 0 && r_cyc.size() > 0)
      check_eq("stale_capture_cycle", 32'(r_cyc[0] - (s_cyc[0] + 1)), 32'd2);

    // Reset in the middle of WAIT
    do_reset();
    mode = M_NORMAL;
    mul_valid = 1'b0;
    lat = 20;
    set_op(1, 8'h04, 8'h04);
    req = 4'b0010;
    repeat (4) tick();
    check_eq("mid_wait_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("midrst");
    repeat (25) tick();
    check_eq("midrst_no_rsp", 32'(r_z.size()), 32'd0);
    set_op(0, 8'h07, 8'hFE);   // 7 * -2
    set_op(3, 8'h01, 8'h01);
    req = 4'b1001;
    wait_rsp(1, 40);
    check_grant(1, 0);
    check_rsp(0, 2'd0, 16'hFFF2, 1'b0);   // -14
    wait_rsp(2, 40);
    check_grant(2, 3);
    check_rsp(1, 2'd3, 16'h0001, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
